// File: rtl/alu_issue_stage_if.sv
// Request/result bus of the ALU issue stage: request channel in, result channel out.
interface alu_issue_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_opA;
    logic [31:0] in_opB;
    logic [2:0]  in_cmd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_carryout;
    logic        out_zero;
    logic        out_overflow;
    logic        out_err;

    // Issue stage side: accepts requests, produces results.
    modport slave (
        input  in_valid, in_opA, in_opB, in_cmd, out_ready,
        output in_ready, out_valid, out_result, out_carryout, out_zero,
               out_overflow, out_err
    );

    // Surrounding datapath side: issues requests, consumes results.
    modport master (
        output in_valid, in_opA, in_opB, in_cmd, out_ready,
        input  in_ready, out_valid, out_result, out_carryout, out_zero,
               out_overflow, out_err
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: request FIFO feeding a combinational ALU, with a registered
// result slot, sticky ADD/SUB flags and a saturating legal-operation counter.
module alu_issue_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_issue_stage_if.slave bus,
    output logic [31:0]      alu_operandA,
    output logic [31:0]      alu_operandB,
    output logic [2:0]       alu_command,
    input  logic [31:0]      alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             clear_sticky,
    output logic             sticky_overflow,
    output logic             sticky_carry,
    output logic [CNT_W-1:0] op_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]      opa_q [DEPTH];
    logic [31:0]      opb_q [DEPTH];
    logic [2:0]       cmd_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;

    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_result_q;
    logic             out_carry_q, out_zero_q, out_ovf_q, out_err_q;
    logic             sticky_ovf_q, sticky_carry_q;
    logic [CNT_W-1:0] op_count_q;

    logic             fifo_empty, push, capture, head_illegal, head_addsub;

    assign fifo_empty   = (cnt_q == '0);
    assign bus.in_ready = (cnt_q != FULL_CNT);
    assign push         = bus.in_valid && bus.in_ready;
    assign capture      = !fifo_empty && (!out_valid_q || bus.out_ready);

    assign alu_operandA = fifo_empty ? 32'd0 : opa_q[rd_ptr_q];
    assign alu_operandB = fifo_empty ? 32'd0 : opb_q[rd_ptr_q];
    assign alu_command  = fifo_empty ? 3'd0  : cmd_q[rd_ptr_q];
    assign head_illegal = (alu_command > 3'd4);
    assign head_addsub  = (alu_command == 3'd0) || (alu_command == 3'd1);

    // Next occupancy and result-slot valid from this cycle's push/capture/drain.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !capture)
            cnt_d = cnt_q + 1'b1;
        else if (!push && capture)
            cnt_d = cnt_q - 1'b1;
        out_valid_d = out_valid_q;
        if (capture)
            out_valid_d = 1'b1;
        else if (out_valid_q && bus.out_ready)
            out_valid_d = 1'b0;
    end

    // FIFO storage; contents are meaningless while the occupancy count says empty.
    always_ff @(posedge clk) begin
        if (push) begin
            opa_q[wr_ptr_q] <= bus.in_opA;
            opb_q[wr_ptr_q] <= bus.in_opB;
            cmd_q[wr_ptr_q] <= bus.in_cmd;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (capture)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Result register: illegal commands capture a zeroed result with the error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_carry_q  <= 1'b0;
            out_zero_q   <= 1'b0;
            out_ovf_q    <= 1'b0;
            out_err_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (capture) begin
                out_result_q <= head_illegal ? 32'd0 : alu_result;
                out_carry_q  <= !head_illegal && alu_carryout;
                out_zero_q   <= !head_illegal && alu_zero;
                out_ovf_q    <= !head_illegal && alu_overflow;
                out_err_q    <= head_illegal;
            end
        end
    end

    // Sticky flags and saturating count of legal captures; clear wins over set.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_ovf_q   <= 1'b0;
            sticky_carry_q <= 1'b0;
            op_count_q     <= '0;
        end else begin
            if (clear_sticky) begin
                sticky_ovf_q   <= 1'b0;
                sticky_carry_q <= 1'b0;
            end else if (capture && !head_illegal && head_addsub) begin
                sticky_ovf_q   <= sticky_ovf_q | alu_overflow;
                sticky_carry_q <= sticky_carry_q | alu_carryout;
            end
            if (capture && !head_illegal && (op_count_q != '1))
                op_count_q <= op_count_q + 1'b1;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_result   = out_result_q;
    assign bus.out_carryout = out_carry_q;
    assign bus.out_zero     = out_zero_q;
    assign bus.out_overflow = out_ovf_q;
    assign bus.out_err      = out_err_q;
    assign sticky_overflow  = sticky_ovf_q;
    assign sticky_carry     = sticky_carry_q;
    assign op_count         = op_count_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a behavioural ALU drives the DUT's ALU inputs and a
// queue-based model of the stage predicts every output each cycle.
module tb_alu_issue_stage;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        o;
    } alu_out_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  cmd;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] alu_operandA, alu_operandB, alu_result;
    logic [2:0]  alu_command;
    logic        alu_carryout, alu_zero, alu_overflow;
    logic        clear_sticky, sticky_overflow, sticky_carry;
    logic [CNT_W-1:0] op_count;

    alu_issue_stage_if bus ();

    alu_issue_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(rst), .bus(bus),
        .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
        .alu_command(alu_command), .alu_result(alu_result),
        .alu_carryout(alu_carryout), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .clear_sticky(clear_sticky),
        .sticky_overflow(sticky_overflow), .sticky_carry(sticky_carry),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Behavioural 32-bit ALU; unknown commands return junk so the bench can see it ignored.
    function automatic alu_out_t alu_fn(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] cmd);
        alu_out_t r;
        logic [32:0] w;
        r = '0;
        case (cmd)
            3'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r.res = w[31:0];
                r.c = w[32];
                r.o = (a[31] == b[31]) && (r.res[31] != a[31]);
            end
            3'd1: begin
                r.res = a - b;
                r.c = (a >= b);
                r.o = (a[31] != b[31]) && (r.res[31] != a[31]);
            end
            3'd2: r.res = a ^ b;
            3'd3: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: r.res = (a != b) ? 32'd1 : 32'd0;
            default: begin
                r.res = 32'hDEAD_BEEF;
                r.c = 1'b1;
                r.o = 1'b1;
            end
        endcase
        r.z = (cmd <= 3'd4) ? (r.res == 32'd0) : 1'b1;
        return r;
    endfunction

    always_comb begin
        alu_out_t r;
        r = alu_fn(alu_operandA, alu_operandB, alu_command);
        alu_result   = r.res;
        alu_carryout = r.c;
        alu_zero     = r.z;
        alu_overflow = r.o;
    end

    // Reference model state.
    req_t        mq[$];
    bit          m_ov, m_c, m_z, m_o, m_err, m_sov, m_sc, m_pushed;
    logic [31:0] m_res;
    int          m_cnt;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ov = 0; m_res = '0; m_c = 0; m_z = 0; m_o = 0; m_err = 0;
        m_sov = 0; m_sc = 0; m_cnt = 0;
    endtask

    // One clock: check all outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        bit push, cap;
        req_t h, n;
        alu_out_t r;
        @(negedge clk);
        chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < DEPTH));
        chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
        if (m_ov) begin
            chk("out_result", 64'(bus.out_result), 64'(m_res));
            chk("out_flags", 64'({bus.out_carryout, bus.out_zero, bus.out_overflow, bus.out_err}),
                64'({m_c, m_z, m_o, m_err}));
        end
        chk("sticky", 64'({sticky_overflow, sticky_carry}), 64'({m_sov, m_sc}));
        chk("op_count", 64'(op_count), 64'(m_cnt));
        if (mq.size() == 0)
            chk("alu_drive_idle", 64'({alu_operandA, alu_command}), 64'd0);
        else
            chk("alu_drive_head", 64'({alu_operandA, alu_operandB[28:0], alu_command}),
                64'({mq[0].a, mq[0].b[28:0], mq[0].cmd}));
        push = bus.in_valid && (mq.size() < DEPTH);
        cap  = (mq.size() > 0) && (!m_ov || bus.out_ready);
        n.a = bus.in_opA; n.b = bus.in_opB; n.cmd = bus.in_cmd;
        @(posedge clk);
        m_pushed = push && !rst;
        if (rst) begin
            model_reset();
        end else begin
            if (cap) begin
                h = mq.pop_front();
                if (h.cmd > 3'd4) begin
                    m_res = '0; m_c = 0; m_z = 0; m_o = 0; m_err = 1;
                end else begin
                    r = alu_fn(h.a, h.b, h.cmd);
                    m_res = r.res; m_c = r.c; m_z = r.z; m_o = r.o; m_err = 0;
                    if (m_cnt < CNT_MAX) m_cnt++;
                    if (h.cmd <= 3'd1 && !clear_sticky) begin
                        m_sov |= r.o;
                        m_sc  |= r.c;
                    end
                end
                m_ov = 1;
            end else if (m_ov && bus.out_ready) begin
                m_ov = 0;
            end
            if (clear_sticky) begin
                m_sov = 0;
                m_sc  = 0;
            end
            if (push) mq.push_back(n);
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] cmd);
        bus.in_valid = v;
        bus.in_opA = a;
        bus.in_opB = b;
        bus.in_cmd = cmd;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int i, acc;
        rst = 1'b1;
        clear_sticky = 1'b0;
        bus.out_ready = 1'b1;
        drive(0, 0, 0, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_op_count", 64'(op_count), 64'd0);

        // Basic add
        drive(1, 32'd1, 32'd1, 3'd0); cycle();
        drive(0, 0, 0, 0); cycle();
        chk("add_valid", 64'(bus.out_valid), 64'd1);
        chk("add_result", 64'(bus.out_result), 64'd2);
        chk("add_zero", 64'(bus.out_zero), 64'd0);
        chk("add_count", 64'(op_count), 64'd1);

        // SUB giving zero then SLT back to back
        do_reset();
        drive(1, 32'd5, 32'd5, 3'd1); cycle();
        drive(1, 32'hFFFF_FFFF, 32'd1, 3'd3); cycle();
        chk("sub_result", 64'({bus.out_result, bus.out_zero}), 64'({32'd0, 1'b1}));
        drive(0, 0, 0, 0); cycle();
        chk("slt_result", 64'({bus.out_result, bus.out_zero}), 64'({32'd1, 1'b0}));
        chk("slt_count", 64'(op_count), 64'd2);

        // Overflow and sticky behaviour
        do_reset();
        drive(1, 32'h7FFF_FFFF, 32'd1, 3'd0); cycle();
        drive(0, 0, 0, 0); cycle();
        chk("ovf_flag", 64'({bus.out_overflow, bus.out_result}), 64'({1'b1, 32'h8000_0000}));
        chk("ovf_sticky", 64'(sticky_overflow), 64'd1);
        drive(1, 32'h0000_00F0, 32'h0000_000F, 3'd2); cycle();
        drive(0, 0, 0, 0); cycle();
        chk("xor_keeps_sticky", 64'({sticky_overflow, bus.out_result}), 64'({1'b1, 32'hFF}));
        clear_sticky = 1'b1; cycle();
        clear_sticky = 1'b0;
        chk("sticky_cleared", 64'(sticky_overflow), 64'd0);

        // Backpressure: only DEPTH+1 requests fit while the consumer stalls
        do_reset();
        bus.out_ready = 1'b0;
        i = 1; acc = 0;
        for (int k = 0; k < 6; k++) begin
            drive(i <= 4, i, 0, 3'd0);
            cycle();
            if (m_pushed) begin acc++; i++; end
        end
        chk("bp_accepted", 64'(acc), 64'(DEPTH + 1));
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        chk("bp_head", 64'(bus.out_result), 64'd1);
        drive(0, 0, 0, 0);
        bus.out_ready = 1'b1;
        cycle();
        chk("bp_second", 64'(bus.out_result), 64'd2);
        cycle();
        chk("bp_third", 64'(bus.out_result), 64'd3);
        chk("bp_in_ready_back", 64'(bus.in_ready), 64'd1);
        cycle();

        // Illegal command between two ADDs
        do_reset();
        drive(1, 32'd1, 32'd2, 3'd0); cycle();
        drive(1, 32'd3, 32'd4, 3'd6); cycle();
        drive(1, 32'd4, 32'd4, 3'd0); cycle();
        chk("illegal_err", 64'({bus.out_err, bus.out_result}), 64'({1'b1, 32'd0}));
        drive(0, 0, 0, 0); cycle();
        chk("illegal_count", 64'(op_count), 64'd2);
        chk("illegal_sticky", 64'({sticky_overflow, sticky_carry}), 64'd0);

        // Reset in the middle of stalled traffic
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'(k + 10), 32'd1, 3'd0);
            cycle();
        end
        drive(0, 0, 0, 0);
        do_reset();
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst_count", 64'(op_count), 64'd0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle();

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a, b;
            a = (k % 4 == 0) ? 32'h7FFF_FFFF + 32'($urandom_range(0, 2)) : $urandom;
            b = (k % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            drive($urandom_range(0, 3) != 0, a, b, 3'($urandom_range(0, 7)));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            clear_sticky = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;
        clear_sticky = 1'b0;

        // Counter saturation
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < CNT_MAX + 3; k++) begin
            drive(1, 32'(k), 32'd1, 3'd4);
            cycle();
        end
        drive(0, 0, 0, 0);
        cycle();
        chk("count_saturated", 64'(op_count), 64'(CNT_MAX));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream issue/capture stage for the 32-bit combinational ALU (commands ADD=0, SUB=1, XOR=2, SLT=3, CNE=4).
- Accepts operation requests over a valid/ready handshake and buffers them in a small FIFO.
- Presents the FIFO head to the ALU and registers the ALU outputs into a result register with its own valid/ready handshake.
- Keeps sticky overflow/carry flags and a count of completed operations for the surrounding datapath.

Parameters:
DEPTH, 2, request FIFO entries (power of two, 2..16)
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  request present
in_ready  output  1  stage can accept request this cycle
in_opA  input  32  operand A
in_opB  input  32  operand B
in_cmd  input  3  ALU command
alu_operandA  output  32  to ALU operandA (FIFO head)
alu_operandB  output  32  to ALU operandB (FIFO head)
alu_command  output  3  to ALU command (FIFO head)
alu_result  input  32  from ALU
alu_carryout  input  1  from ALU
alu_zero  input  1  from ALU
alu_overflow  input  1  from ALU
out_valid  output  1  result register holds unconsumed result
out_ready  input  1  consumer accepts result this cycle
out_result  output  32  registered result
out_carryout  output  1  registered carryout
out_zero  output  1  registered zero
out_overflow  output  1  registered overflow
out_err  output  1  registered illegal-command flag
clear_sticky  input  1  clear sticky flags
sticky_overflow  output  1  any legal ADD/SUB captured with overflow since clear
sticky_carry  output  1  any legal ADD/SUB captured with carryout since clear
op_count  output  CNT_W  legal operations captured, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: FIFO empty, in_ready=1, out_valid=0, out_result=0, all out_* flags=0, sticky flags=0, op_count=0.
- Reset asserted mid-operation discards FIFO contents and any held result in the same edge. No partial transfer survives.
- Push: occurs when in_valid && in_ready. in_ready = !fifo_full; it is purely a function of registered state and does not depend on in_valid.
- ALU drive: alu_operandA/B/command come from the FIFO head combinationally. When the FIFO is empty they are 0/0/3'd0.
- Capture condition: fifo_not_empty && (!out_valid || out_ready).
  - On capture, the ALU outputs load into out_* and the head is popped.
  - out_valid is set at that edge.
- Release: out_valid clears when out_valid && out_ready && no capture in the same cycle.
- Simultaneous drain and capture keep out_valid=1 with new data, giving full throughput of 1 op/cycle.
- Latency: request accepted at edge N is captured at edge N+1 at the earliest, so out_valid is visible in cycle N+1.
- Simultaneous push and pop in one cycle are both honoured, and occupancy is unchanged. A push when full is impossible because in_ready=0.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. An occupancy counter of log2(DEPTH)+1 bits distinguishes full from empty.
- Capacity under stall: DEPTH entries plus 1 held result, i.e. DEPTH+1 requests accepted with out_ready=0.
- Illegal command (in_cmd 5..7): still queued and captured in order. The capture loads out_result=0, out_carryout=out_zero=out_overflow=0 and out_err=1, ignoring the ALU outputs. It does not affect sticky flags or op_count.
- Legal capture: out_err=0 and op_count increments by 1. op_count saturates at 2^CNT_W-1 and does not wrap.
- Sticky flags:
  - On legal capture of ADD or SUB, sticky_overflow |= alu_overflow and sticky_carry |= alu_carryout.
  - Other commands never set sticky flags.
  - clear_sticky has priority over a set in the same cycle; both flags become 0.
- Order: results emerge strictly in request order.

Test Plan:
- Basic add: after reset, push opA=1, opB=1, cmd=ADD with out_ready=1 → out_valid=1 one cycle later, out_result=2, out_zero=0, op_count=1.
- Sub/zero and SLT: push SUB 5,5 then SLT 0xFFFFFFFF,1 back-to-back → consecutive cycles yield result 0 with zero=1, then result 1 with zero=0; op_count=2.
- Overflow sticky: push ADD 0x7FFFFFFF,1 → out_overflow=1, out_result=0x80000000, sticky_overflow=1. Push XOR with overflow-free operands → sticky_overflow remains 1. Pulse clear_sticky → 0 next cycle.
- Backpressure: hold out_ready=0 and drive in_valid=1 continuously with ADD i,0 for i=1..4 → exactly 3 accepted (in_ready low after third). Raise out_ready → results 1,2,3 emerge in order on consecutive cycles, then in_ready returns 1.
- Illegal command: push cmd=3'd6, opA=3, opB=4 between two legal ADDs → middle result has out_err=1, out_result=0; op_count increments by 2 only; sticky flags unchanged.
- Reset mid-operation: with 2 queued requests and out_valid=1 held, assert reset for one edge → out_valid=0, in_ready=1, op_count=0, and no stale result appears after reset deasserts.
